// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Tuse/Tnew register hazards,
// HI/LO mult/div busy tracking, and a free-running stall-cycle counter.
module pipe_hazard_ctrl #(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  d_rs_addr,
   input  logic [4:0]  d_rt_addr,
   input  logic [1:0]  d_tuse_rs,
   input  logic [1:0]  d_tuse_rt,
   input  logic        d_is_md,
   input  logic [4:0]  e_wr_addr,
   input  logic [1:0]  e_tnew,
   input  logic [4:0]  m_wr_addr,
   input  logic [1:0]  m_tnew,
   input  logic        e_md_start,
   input  logic        e_md_div,
   output logic        stall,
   output logic        f_we,
   output logic        d_we,
   output logic        e_clr,
   output logic        m_we,
   output logic        w_we,
   output logic        md_busy,
   output logic        md_err,
   output logic [31:0] stall_cnt
);

   logic [3:0]  md_cnt_q, md_cnt_d;
   logic        md_err_q, md_err_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic haz_rs_e, haz_rs_m, haz_rt_e, haz_rt_m, haz_md;
   logic md_busy_raw, stall_raw;

   // A Tuse of 3 can never be below a 2-bit Tnew, so unused operands drop out naturally.
   always_comb begin
      haz_rs_e    = (d_rs_addr != 5'd0) && (d_rs_addr == e_wr_addr) && (d_tuse_rs < e_tnew);
      haz_rs_m    = (d_rs_addr != 5'd0) && (d_rs_addr == m_wr_addr) && (d_tuse_rs < m_tnew);
      haz_rt_e    = (d_rt_addr != 5'd0) && (d_rt_addr == e_wr_addr) && (d_tuse_rt < e_tnew);
      haz_rt_m    = (d_rt_addr != 5'd0) && (d_rt_addr == m_wr_addr) && (d_tuse_rt < m_tnew);
      md_busy_raw = e_md_start || (md_cnt_q != 4'd0);
      haz_md      = d_is_md && md_busy_raw;
      stall_raw   = haz_rs_e || haz_rs_m || haz_rt_e || haz_rt_m || haz_md;
   end

   // Reset masks the decode so the stage registers see a clean advance during reset.
   always_comb begin
      stall     = stall_raw && !reset;
      md_busy   = md_busy_raw && !reset;
      f_we      = !stall;
      d_we      = !stall;
      e_clr     = stall;
      m_we      = 1'b1;
      w_we      = 1'b1;
      md_err    = md_err_q;
      stall_cnt = stall_cnt_q;
   end

   always_comb begin
      md_cnt_d    = md_cnt_q;
      md_err_d    = md_err_q;
      stall_cnt_d = stall_cnt_q + {31'd0, stall};
      if (reset) begin
         md_cnt_d    = 4'd0;
         md_err_d    = 1'b0;
         stall_cnt_d = 32'd0;
      end else if (e_md_start) begin
         md_cnt_d = e_md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
         if (md_cnt_q != 4'd0) begin
            md_err_d = 1'b1;
         end
      end else if (md_cnt_q != 4'd0) begin
         md_cnt_d = md_cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      md_cnt_q    <= md_cnt_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a cycle-indexed reference model.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  d_rs_addr, d_rt_addr, e_wr_addr, m_wr_addr;
   logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
   logic        d_is_md, e_md_start, e_md_div;
   logic        stall, f_we, d_we, e_clr, m_we, w_we, md_busy, md_err;
   logic [31:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: mult/div busy expressed as "busy through cycle N".
   int          cyc        = 0;
   int          busy_until = -1;
   bit          known      = 0;
   bit          err_m      = 0;
   logic [31:0] scnt_m     = 32'd0;

   logic obs_stall, obs_busy, obs_err;
   logic [31:0] obs_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk(clk), .reset(reset),
      .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md),
      .e_wr_addr(e_wr_addr), .e_tnew(e_tnew),
      .m_wr_addr(m_wr_addr), .m_tnew(m_tnew),
      .e_md_start(e_md_start), .e_md_div(e_md_div),
      .stall(stall), .f_we(f_we), .d_we(d_we), .e_clr(e_clr),
      .m_we(m_we), .w_we(w_we), .md_busy(md_busy), .md_err(md_err),
      .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic set_idle();
      reset = 0; d_rs_addr = 0; d_rt_addr = 0; d_tuse_rs = 3; d_tuse_rt = 3;
      d_is_md = 0; e_wr_addr = 0; e_tnew = 0; m_wr_addr = 0; m_tnew = 0;
      e_md_start = 0; e_md_div = 0;
   endtask

   function automatic bit reg_haz(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] dst, input logic [1:0] tnew);
      return (src != 0) && (src == dst) && (int'(tuse) < int'(tnew));
   endfunction

   // One cycle: check outputs at negedge, advance model across the posedge.
   task automatic tick();
      bit exp_busy, exp_stall;
      @(negedge clk);
      if (reset) begin
         exp_busy  = 0;
         exp_stall = 0;
      end else begin
         exp_busy  = e_md_start || (cyc <= busy_until);
         exp_stall = reg_haz(d_rs_addr, d_tuse_rs, e_wr_addr, e_tnew) ||
                     reg_haz(d_rs_addr, d_tuse_rs, m_wr_addr, m_tnew) ||
                     reg_haz(d_rt_addr, d_tuse_rt, e_wr_addr, e_tnew) ||
                     reg_haz(d_rt_addr, d_tuse_rt, m_wr_addr, m_tnew) ||
                     (d_is_md && exp_busy);
      end
      obs_stall = stall; obs_busy = md_busy; obs_err = md_err; obs_cnt = stall_cnt;
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("f_we",  {31'd0, f_we},  {31'd0, !exp_stall});
      chk("d_we",  {31'd0, d_we},  {31'd0, !exp_stall});
      chk("e_clr", {31'd0, e_clr}, {31'd0, exp_stall});
      chk("m_w_we", {30'd0, m_we, w_we}, 32'd3);
      chk("md_busy", {31'd0, md_busy}, {31'd0, exp_busy});
      if (known) begin
         chk("md_err", {31'd0, md_err}, {31'd0, err_m});
         chk("stall_cnt", stall_cnt, scnt_m);
      end
      if (reset) begin
         busy_until = -1; err_m = 0; scnt_m = 0; known = 1;
      end else begin
         if (e_md_start) begin
            if (cyc <= busy_until) err_m = 1;
            busy_until = cyc + (e_md_div ? 10 : 5);
         end
         if (exp_stall) scnt_m = scnt_m + 1;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      set_idle(); reset = 1; tick(); set_idle();
   endtask

   initial begin
      set_idle(); reset = 1;
      #1; tick(); tick(); set_idle();
      chk("rst_cnt", stall_cnt, 32'd0);
      chk("rst_err", {31'd0, md_err}, 32'd0);

      // lw $1 in E, addu in D reads $1 early
      e_wr_addr = 1; e_tnew = 2; d_rs_addr = 1; d_tuse_rs = 1; tick();
      chk("t1_stall", {31'd0, obs_stall}, 32'd1);
      e_wr_addr = 0; e_tnew = 0; m_wr_addr = 1; m_tnew = 1; tick();
      chk("t1_adv", {31'd0, obs_stall}, 32'd0);

      // $0 and unused operand never hazard
      set_idle(); d_rs_addr = 0; d_tuse_rs = 1; e_wr_addr = 0; e_tnew = 2; tick();
      chk("t2_r0", {31'd0, obs_stall}, 32'd0);
      set_idle(); d_rt_addr = 2; d_tuse_rt = 3; e_wr_addr = 2; e_tnew = 2; tick();
      chk("t2_unused", {31'd0, obs_stall}, 32'd0);

      // mult then mflo in D: stalls t..t+5
      set_idle(); d_is_md = 1; e_md_start = 1; e_md_div = 0;
      for (int i = 0; i < 6; i++) begin
         tick(); e_md_start = 0;
         chk("t3_mult_stall", {31'd0, obs_stall}, 32'd1);
      end
      tick(); chk("t3_mult_free", {31'd0, obs_stall}, 32'd0);
      e_md_start = 1; e_md_div = 1;
      for (int i = 0; i < 11; i++) begin
         tick(); e_md_start = 0;
         chk("t3_div_stall", {31'd0, obs_stall}, 32'd1);
      end
      tick(); chk("t3_div_free", {31'd0, obs_stall}, 32'd0);

      // reset mid-div
      set_idle(); e_md_start = 1; e_md_div = 1; tick(); set_idle(); tick();
      do_reset(); d_is_md = 1; tick();
      chk("t4_busy", {31'd0, obs_busy}, 32'd0);
      chk("t4_stall", {31'd0, obs_stall}, 32'd0);

      // three forced stalls
      do_reset();
      e_wr_addr = 7; e_tnew = 3; d_rt_addr = 7; d_tuse_rt = 0;
      repeat (3) tick();
      set_idle(); tick();
      chk("t5_cnt", obs_cnt, 32'd3);

      // illegal back-to-back mult
      set_idle(); e_md_start = 1; tick(); e_md_start = 0; tick();
      e_md_start = 1; tick(); e_md_start = 0; tick();
      chk("t6_err", {31'd0, obs_err}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick(); chk("t6_reload_busy", {31'd0, obs_busy}, 32'd1);
      end
      tick(); chk("t6_idle", {31'd0, obs_busy}, 32'd0);
      chk("t6_sticky", {31'd0, obs_err}, 32'd1);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         reset      = ($urandom_range(0, 199) == 0);
         d_rs_addr  = 5'($urandom_range(0, 3));
         d_rt_addr  = 5'($urandom_range(0, 3));
         d_tuse_rs  = 2'($urandom);
         d_tuse_rt  = 2'($urandom);
         d_is_md    = ($urandom_range(0, 3) == 0);
         e_wr_addr  = 5'($urandom_range(0, 3));
         e_tnew     = 2'($urandom);
         m_wr_addr  = 5'($urandom_range(0, 3));
         m_tnew     = 2'($urandom);
         e_md_start = ($urandom_range(0, 9) == 0);
         e_md_div   = 1'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
